// File: rtl/vip_input_frame_sequencer.sv
// ---------------------------------------------------------------------------
// vip_input_frame_sequencer
//
// Sits between the VIP flow-control input stage and the algorithm core. It
// paces the incoming stall/read-style active-video stream with `read`,
// tracks the pixel/line position against the latched frame geometry and
// presents each accepted beat on a registered valid/ready output carrying
// start/end-of-line and start/end-of-frame markers. Frames that end early or
// late relative to the programmed geometry raise `frame_error`, and the block
// re-aligns to the next packet boundary.
//
// Ports
//   clk                 sole clock
//   rst                 asynchronous reset, active low
//   stall_in            high = no active-video beat available this cycle
//   data_in             beat data (BITS_PER_SYMBOL*SYMBOLS_PER_BEAT bits)
//   end_of_video_in     last beat of the current video packet
//   width_in/height_in  decoder geometry (beats per line / lines per frame)
//   interlaced_in       decoder interlace nibble
//   vip_ctrl_valid_in   geometry fields valid this cycle
//   read                accept the current beat (combinational)
//   enable              permit new frames to start (sampled in IDLE only)
//   dout_valid/ready    registered output handshake
//   dout_data           registered beat data
//   dout_sol/eol/sof/eof line and frame markers for dout_data
//   dout_interlaced     interlace nibble of the current frame
//   x_count/y_count     position of the next beat to be accepted
//   busy                a frame is active or being drained
//   frame_error         one-cycle pulse on bad geometry or early/late end
// ---------------------------------------------------------------------------
module vip_input_frame_sequencer #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3,
   localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_in,
   input  logic [DW-1:0] data_in,
   input  logic          end_of_video_in,
   input  logic [15:0]   width_in,
   input  logic [15:0]   height_in,
   input  logic [3:0]    interlaced_in,
   input  logic          vip_ctrl_valid_in,
   output logic          read,
   input  logic          enable,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout_data,
   output logic          dout_sol,
   output logic          dout_eol,
   output logic          dout_sof,
   output logic          dout_eof,
   output logic [3:0]    dout_interlaced,
   output logic [15:0]   x_count,
   output logic [15:0]   y_count,
   output logic          busy,
   output logic          frame_error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t        state_q, state_d;

   logic [15:0]   pendWidth_q, pendWidth_d;
   logic [15:0]   pendHeight_q, pendHeight_d;
   logic [3:0]    pendInterlaced_q, pendInterlaced_d;
   logic          pendValid_q, pendValid_d;

   logic [15:0]   actWidth_q, actWidth_d;
   logic [15:0]   actHeight_q, actHeight_d;
   logic [3:0]    actInterlaced_q, actInterlaced_d;

   logic [15:0]   xCount_q, xCount_d;
   logic [15:0]   yCount_q, yCount_d;

   logic          doutValid_q, doutValid_d;
   logic [DW-1:0] doutData_q, doutData_d;
   logic          doutSol_q, doutSol_d;
   logic          doutEol_q, doutEol_d;
   logic          doutSof_q, doutSof_d;
   logic          doutEof_q, doutEof_d;

   logic          frameError_q, frameError_d;

   logic          ctrlBad;
   logic          ctrlGood;
   logic          xLast;
   logic          yLast;
   logic          frameLast;
   logic          readBeat;

   // A control packet with a zero dimension is rejected outright so the
   // previously programmed geometry stays usable for the next frame.
   assign ctrlBad   = vip_ctrl_valid_in & ((width_in == 16'd0) | (height_in == 16'd0));
   assign ctrlGood  = vip_ctrl_valid_in & ~ctrlBad;

   // Position compares against the geometry latched at frame start, so a
   // control packet arriving mid-frame cannot disturb the frame in flight.
   assign xLast     = (xCount_q == (actWidth_q - 16'd1));
   assign yLast     = (yCount_q == (actHeight_q - 16'd1));
   assign frameLast = xLast & yLast;

   // Next-state logic. `read` is produced here straight from the current
   // state and the handshake inputs so there is no register in the read path;
   // in ACTIVE a beat is only pulled when the output register is free or is
   // being emptied this cycle.
   always_comb begin
      state_d          = state_q;
      pendWidth_d      = pendWidth_q;
      pendHeight_d     = pendHeight_q;
      pendInterlaced_d = pendInterlaced_q;
      pendValid_d      = pendValid_q;
      actWidth_d       = actWidth_q;
      actHeight_d      = actHeight_q;
      actInterlaced_d  = actInterlaced_q;
      xCount_d         = xCount_q;
      yCount_d         = yCount_q;
      doutValid_d      = doutValid_q;
      doutData_d       = doutData_q;
      doutSol_d        = doutSol_q;
      doutEol_d        = doutEol_q;
      doutSof_d        = doutSof_q;
      doutEof_d        = doutEof_q;
      frameError_d     = ctrlBad;
      readBeat         = 1'b0;

      if (ctrlGood) begin
         pendWidth_d      = width_in;
         pendHeight_d     = height_in;
         pendInterlaced_d = interlaced_in;
         pendValid_d      = 1'b1;
      end

      if (doutValid_q & dout_ready) begin
         doutValid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // Geometry is copied from the pending registers as they stand;
            // a capture landing in this same cycle belongs to the next frame.
            if (enable & pendValid_q) begin
               state_d         = ACTIVE;
               actWidth_d      = pendWidth_q;
               actHeight_d     = pendHeight_q;
               actInterlaced_d = pendInterlaced_q;
               xCount_d        = 16'd0;
               yCount_d        = 16'd0;
            end
         end

         ACTIVE: begin
            readBeat = ~stall_in & (~doutValid_q | dout_ready);
            if (readBeat) begin
               doutValid_d = 1'b1;
               doutData_d  = data_in;
               doutSol_d   = (xCount_q == 16'd0);
               doutSof_d   = (xCount_q == 16'd0) & (yCount_q == 16'd0);
               // An early end of packet closes both the line and the frame
               // on this beat so downstream sees a well-formed frame.
               doutEol_d   = xLast | end_of_video_in;
               doutEof_d   = frameLast | end_of_video_in;

               if (xLast) begin
                  xCount_d = 16'd0;
                  yCount_d = yCount_q + 16'd1;
               end else begin
                  xCount_d = xCount_q + 16'd1;
               end

               if (end_of_video_in) begin
                  state_d = IDLE;
                  if (~frameLast) begin
                     frameError_d = 1'b1;
                  end
               end else if (frameLast) begin
                  // Packet is longer than the geometry: swallow the rest.
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            readBeat = ~stall_in;
            if (readBeat & end_of_video_in) begin
               frameError_d = 1'b1;
               state_d      = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         pendWidth_q      <= 16'd0;
         pendHeight_q     <= 16'd0;
         pendInterlaced_q <= 4'd0;
         pendValid_q      <= 1'b0;
         actWidth_q       <= 16'd0;
         actHeight_q      <= 16'd0;
         actInterlaced_q  <= 4'd0;
         xCount_q         <= 16'd0;
         yCount_q         <= 16'd0;
         doutValid_q      <= 1'b0;
         doutData_q       <= '0;
         doutSol_q        <= 1'b0;
         doutEol_q        <= 1'b0;
         doutSof_q        <= 1'b0;
         doutEof_q        <= 1'b0;
         frameError_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         pendWidth_q      <= pendWidth_d;
         pendHeight_q     <= pendHeight_d;
         pendInterlaced_q <= pendInterlaced_d;
         pendValid_q      <= pendValid_d;
         actWidth_q       <= actWidth_d;
         actHeight_q      <= actHeight_d;
         actInterlaced_q  <= actInterlaced_d;
         xCount_q         <= xCount_d;
         yCount_q         <= yCount_d;
         doutValid_q      <= doutValid_d;
         doutData_q       <= doutData_d;
         doutSol_q        <= doutSol_d;
         doutEol_q        <= doutEol_d;
         doutSof_q        <= doutSof_d;
         doutEof_q        <= doutEof_d;
         frameError_q     <= frameError_d;
      end
   end

   assign read            = readBeat;
   assign dout_valid      = doutValid_q;
   assign dout_data       = doutData_q;
   assign dout_sol        = doutSol_q;
   assign dout_eol        = doutEol_q;
   assign dout_sof        = doutSof_q;
   assign dout_eof        = doutEof_q;
   assign dout_interlaced = actInterlaced_q;
   assign x_count         = xCount_q;
   assign y_count         = yCount_q;
   assign busy            = (state_q != IDLE);
   assign frame_error     = frameError_q;

endmodule

// File: tb/tb_vip_input_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vip_input_frame_sequencer
//
// Self-checking bench for vip_input_frame_sequencer: a table of whole-frame
// scenarios, hand-written sequences for backpressure, mid-frame geometry
// change and mid-frame reset, and a randomized run against a frame-level
// reference model that derives positions and markers from the beat index.
// ---------------------------------------------------------------------------
module tb_vip_input_frame_sequencer;

   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall_in;
   logic [DW-1:0] data_in;
   logic          end_of_video_in;
   logic [15:0]   width_in;
   logic [15:0]   height_in;
   logic [3:0]    interlaced_in;
   logic          vip_ctrl_valid_in;
   logic          read;
   logic          enable;
   logic          dout_valid;
   logic          dout_ready;
   logic [DW-1:0] dout_data;
   logic          dout_sol;
   logic          dout_eol;
   logic          dout_sof;
   logic          dout_eof;
   logic [3:0]    dout_interlaced;
   logic [15:0]   x_count;
   logic [15:0]   y_count;
   logic          busy;
   logic          frame_error;

   always #5 clk = ~clk;

   vip_input_frame_sequencer #(
      .BITS_PER_SYMBOL  (8),
      .SYMBOLS_PER_BEAT (3)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_in          (stall_in),
      .data_in           (data_in),
      .end_of_video_in   (end_of_video_in),
      .width_in          (width_in),
      .height_in         (height_in),
      .interlaced_in     (interlaced_in),
      .vip_ctrl_valid_in (vip_ctrl_valid_in),
      .read              (read),
      .enable            (enable),
      .dout_valid        (dout_valid),
      .dout_ready        (dout_ready),
      .dout_data         (dout_data),
      .dout_sol          (dout_sol),
      .dout_eol          (dout_eol),
      .dout_sof          (dout_sof),
      .dout_eof          (dout_eof),
      .dout_interlaced   (dout_interlaced),
      .x_count           (x_count),
      .y_count           (y_count),
      .busy              (busy),
      .frame_error       (frame_error)
   );

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Output collector used by the whole-frame scenarios: while collecting,
   // it records one bit per accepted output beat for each marker and counts
   // frame_error pulses; otherwise it keeps its tallies cleared.
   logic        collecting = 1'b0;
   int          outCount;
   int          errCount;
   logic [15:0] solMask, eolMask, sofMask, eofMask;

   always @(negedge clk) begin
      #2;
      if (!collecting) begin
         outCount = 0;
         errCount = 0;
         solMask  = '0;
         eolMask  = '0;
         sofMask  = '0;
         eofMask  = '0;
      end else begin
         if (dout_valid && dout_ready) begin
            if (outCount < 16) begin
               solMask[outCount] = dout_sol;
               eolMask[outCount] = dout_eol;
               sofMask[outCount] = dout_sof;
               eofMask[outCount] = dout_eof;
            end
            outCount++;
         end
         if (frame_error) errCount++;
      end
   end

   task automatic doReset();
      rst               = 1'b0;
      stall_in          = 1'b1;
      data_in           = '0;
      end_of_video_in   = 1'b0;
      width_in          = 16'd0;
      height_in         = 16'd0;
      interlaced_in     = 4'd0;
      vip_ctrl_valid_in = 1'b0;
      enable            = 1'b0;
      dout_ready        = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic sendCtrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
      @(negedge clk);
      stall_in          = 1'b1;
      end_of_video_in   = 1'b0;
      vip_ctrl_valid_in = 1'b1;
      width_in          = w;
      height_in         = h;
      interlaced_in     = il;
      @(negedge clk);
      vip_ctrl_valid_in = 1'b0;
   endtask

   // Presents one beat and waits (bounded) until the block takes it; the
   // beat is consumed at the next rising edge after this task returns.
   task automatic applyStimulus(input logic [DW-1:0] d, input logic e);
      int t;
      @(negedge clk);
      stall_in        = 1'b0;
      data_in         = d;
      end_of_video_in = e;
      #1;
      t = 0;
      while (read !== 1'b1 && t < 20) begin
         @(negedge clk);
         #1;
         t++;
      end
      checkOutput("beatAccepted", {31'd0, read}, 32'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_read"},   {31'd0, read}, 32'd0);
      checkOutput({tag, "_valid"},  {31'd0, dout_valid}, 32'd0);
      checkOutput({tag, "_busy"},   {31'd0, busy}, 32'd0);
      checkOutput({tag, "_ferr"},   {31'd0, frame_error}, 32'd0);
      checkOutput({tag, "_xy"},     {x_count, y_count}, 32'd0);
      checkOutput({tag, "_data"},   {8'd0, dout_data}, 32'd0);
      checkOutput({tag, "_marks"},  {28'd0, dout_sol, dout_eol, dout_sof, dout_eof}, 32'd0);
      checkOutput({tag, "_ilace"},  {28'd0, dout_interlaced}, 32'd0);
   endtask

   // ------------------------------------------------------------------
   // Whole-frame scenario table
   // ------------------------------------------------------------------
   typedef struct {
      logic [15:0] w;
      logic [15:0] h;
      int          nBeats;
      int          expOut;
      int          expErr;
      logic [15:0] sol;
      logic [15:0] eol;
      logic [15:0] sof;
      logic [15:0] eof;
   } vec_t;

   vec_t vecs[6];

   task automatic runFrame(input vec_t v, input int idx);
      doReset();
      checkResetState($sformatf("T%0d_reset", idx));
      enable = 1'b1;
      sendCtrl(v.w, v.h, 4'h5);
      collecting = 1'b1;
      for (int i = 1; i <= v.nBeats; i++) begin
         applyStimulus(DW'(i), (i == v.nBeats));
         enable = 1'b0;
      end
      @(negedge clk);
      stall_in        = 1'b1;
      end_of_video_in = 1'b0;
      repeat (4) @(negedge clk);
      collecting = 1'b0;
      checkOutput($sformatf("T%0d_outCount", idx), outCount, v.expOut);
      checkOutput($sformatf("T%0d_errCount", idx), errCount, v.expErr);
      checkOutput($sformatf("T%0d_sol", idx), {16'd0, solMask}, {16'd0, v.sol});
      checkOutput($sformatf("T%0d_eol", idx), {16'd0, eolMask}, {16'd0, v.eol});
      checkOutput($sformatf("T%0d_sof", idx), {16'd0, sofMask}, {16'd0, v.sof});
      checkOutput($sformatf("T%0d_eof", idx), {16'd0, eofMask}, {16'd0, v.eof});
      checkOutput($sformatf("T%0d_idle", idx), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("T%0d_ilace", idx), {28'd0, dout_interlaced}, 32'h5);
   endtask

   // ------------------------------------------------------------------
   // Backpressure: ready toggles 1,0,0,1 with a continuous source
   // ------------------------------------------------------------------
   task automatic runBackpressure();
      logic          readyPat [4];
      int            nextBeat;
      int            got;
      logic          wasHeld;
      logic [DW-1:0] heldData;
      readyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
      doReset();
      enable = 1'b1;
      sendCtrl(16'd4, 16'd2, 4'h0);
      nextBeat = 1;
      got      = 0;
      wasHeld  = 1'b0;
      heldData = '0;
      for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
         @(negedge clk);
         dout_ready      = readyPat[cyc % 4];
         stall_in        = (nextBeat > 8);
         data_in         = DW'(nextBeat);
         end_of_video_in = (nextBeat == 8);
         #1;
         if (dout_valid && !dout_ready)
            checkOutput("BP_readBlocked", {31'd0, read}, 32'd0);
         if (wasHeld)
            checkOutput("BP_dataHeld", {8'd0, dout_data}, {8'd0, heldData});
         if (dout_valid && dout_ready) begin
            checkOutput("BP_order", {8'd0, dout_data}, got + 1);
            got++;
         end
         wasHeld  = dout_valid && !dout_ready;
         heldData = dout_data;
         if (read) begin
            nextBeat++;
            enable = 1'b0;
         end
      end
      checkOutput("BP_beats", got, 8);
      @(negedge clk);
      stall_in   = 1'b1;
      dout_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("BP_drained", {31'd0, dout_valid}, 32'd0);
   endtask

   // ------------------------------------------------------------------
   // New geometry arriving mid-frame only affects the following frame
   // ------------------------------------------------------------------
   task automatic runMidFrameCtrl();
      doReset();
      enable = 1'b1;
      sendCtrl(16'd4, 16'd1, 4'h2);
      collecting = 1'b1;
      applyStimulus(DW'(1), 1'b0);
      applyStimulus(DW'(2), 1'b0);
      sendCtrl(16'd2, 16'd1, 4'h9);
      applyStimulus(DW'(3), 1'b0);
      applyStimulus(DW'(4), 1'b1);
      applyStimulus(DW'(5), 1'b0);
      enable = 1'b0;
      applyStimulus(DW'(6), 1'b1);
      @(negedge clk);
      stall_in        = 1'b1;
      end_of_video_in = 1'b0;
      repeat (4) @(negedge clk);
      collecting = 1'b0;
      checkOutput("MC_outCount", outCount, 6);
      checkOutput("MC_errCount", errCount, 0);
      checkOutput("MC_sol", {16'd0, solMask}, 32'h11);
      checkOutput("MC_eol", {16'd0, eolMask}, 32'h28);
      checkOutput("MC_sof", {16'd0, sofMask}, 32'h11);
      checkOutput("MC_eof", {16'd0, eofMask}, 32'h28);
      checkOutput("MC_ilace", {28'd0, dout_interlaced}, 32'h9);
   endtask

   // ------------------------------------------------------------------
   // Reset asserted mid-frame
   // ------------------------------------------------------------------
   task automatic runMidFrameReset();
      doReset();
      enable = 1'b1;
      sendCtrl(16'd4, 16'd2, 4'h3);
      applyStimulus(DW'(7), 1'b0);
      applyStimulus(DW'(8), 1'b0);
      applyStimulus(DW'(9), 1'b0);
      @(negedge clk);
      stall_in = 1'b0;
      rst      = 1'b0;
      #1;
      checkResetState("RST_async");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checkOutput("RST_noRead", {31'd0, read}, 32'd0);
         checkOutput("RST_noBusy", {31'd0, busy}, 32'd0);
      end
      stall_in = 1'b1;
   endtask

   // ------------------------------------------------------------------
   // Randomized run against a frame-level reference model
   // ------------------------------------------------------------------
   typedef struct {
      logic [DW-1:0] d;
      logic          e;
   } beat_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          sol;
      logic          eol;
      logic          sof;
      logic          eof;
   } obeat_t;

   task automatic runRandom(input int nCycles);
      beat_t  src[$];
      obeat_t expq[$];
      obeat_t ob;
      int     mPhase;       // 0 idle, 1 in frame, 2 discarding tail
      int     mPw, mPh, mAw, mAh, mK;
      logic [3:0] mPil, mAil;
      logic   mPv, mOcc, mErr;
      logic   expRead, curE, errN, last;
      int     nPhase, len, cw, ch;
      logic [3:0] cil;
      logic   ctrlNow;

      doReset();
      mPhase = 0; mPw = 0; mPh = 0; mAw = 0; mAh = 0; mK = 0;
      mPil = 0; mAil = 0; mPv = 0; mOcc = 0; mErr = 0;

      for (int cyc = 0; cyc < nCycles; cyc++) begin
         @(negedge clk);
         if (src.size() == 0) begin
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
               src.push_back('{d: DW'($urandom), e: (j == len - 1)});
            end
         end
         curE            = src[0].e;
         stall_in        = ($urandom_range(0, 3) == 0);
         data_in         = src[0].d;
         end_of_video_in = curE;
         dout_ready      = ($urandom_range(0, 3) != 0);
         enable          = ($urandom_range(0, 15) != 0);
         ctrlNow         = (cyc == 0) || ($urandom_range(0, 59) == 0);
         cw              = (cyc == 0) ? 3 : $urandom_range(0, 4);
         ch              = (cyc == 0) ? 2 : $urandom_range(0, 3);
         cil             = 4'($urandom);
         vip_ctrl_valid_in = ctrlNow;
         width_in          = 16'(cw);
         height_in         = 16'(ch);
         interlaced_in     = cil;
         #1;

         if (mPhase == 1)      expRead = !stall_in && (!mOcc || dout_ready);
         else if (mPhase == 2) expRead = !stall_in;
         else                  expRead = 1'b0;

         checkOutput("R_read",  {31'd0, read}, {31'd0, expRead});
         checkOutput("R_busy",  {31'd0, busy}, {31'd0, (mPhase != 0)});
         checkOutput("R_valid", {31'd0, dout_valid}, {31'd0, mOcc});
         checkOutput("R_ferr",  {31'd0, frame_error}, {31'd0, mErr});
         checkOutput("R_ilace", {28'd0, dout_interlaced}, {28'd0, mAil});
         if (mPhase == 1) begin
            checkOutput("R_x", {16'd0, x_count}, mK % mAw);
            checkOutput("R_y", {16'd0, y_count}, mK / mAw);
         end
         if (mOcc && dout_ready && expq.size() > 0) begin
            ob = expq.pop_front();
            checkOutput("R_data", {8'd0, dout_data}, {8'd0, ob.d});
            checkOutput("R_marks", {28'd0, dout_sol, dout_eol, dout_sof, dout_eof},
                        {28'd0, ob.sol, ob.eol, ob.sof, ob.eof});
         end

         // Model update for the coming clock edge
         errN   = 1'b0;
         nPhase = mPhase;
         case (mPhase)
            0: begin
               if (enable && mPv) begin
                  nPhase = 1;
                  mAw = mPw; mAh = mPh; mAil = mPil; mK = 0;
               end
            end
            1: begin
               if (expRead) begin
                  last   = (mK == mAw * mAh - 1);
                  ob.d   = src[0].d;
                  ob.sol = ((mK % mAw) == 0);
                  ob.sof = (mK == 0);
                  ob.eol = ((mK % mAw) == mAw - 1) || curE;
                  ob.eof = last || curE;
                  expq.push_back(ob);
                  mK++;
                  if (curE) begin
                     if (!last) errN = 1'b1;
                     nPhase = 0;
                  end else if (last) begin
                     nPhase = 2;
                  end
               end
            end
            default: begin
               if (expRead && curE) begin
                  errN   = 1'b1;
                  nPhase = 0;
               end
            end
         endcase
         if (ctrlNow) begin
            if (cw == 0 || ch == 0) errN = 1'b1;
            else begin
               mPw = cw; mPh = ch; mPil = cil; mPv = 1'b1;
            end
         end
         mOcc   = (mPhase == 1 && expRead) ? 1'b1 : (dout_ready ? 1'b0 : mOcc);
         mPhase = nPhase;
         mErr   = errN;
         if (expRead) void'(src.pop_front());
      end
      @(negedge clk);
      vip_ctrl_valid_in = 1'b0;
      stall_in          = 1'b1;
   endtask

   initial begin
      vecs[0] = '{w: 16'd4, h: 16'd2, nBeats: 8,  expOut: 8, expErr: 0,
                  sol: 16'h0011, eol: 16'h0088, sof: 16'h0001, eof: 16'h0080};
      vecs[1] = '{w: 16'd4, h: 16'd2, nBeats: 5,  expOut: 5, expErr: 1,
                  sol: 16'h0011, eol: 16'h0018, sof: 16'h0001, eof: 16'h0010};
      vecs[2] = '{w: 16'd4, h: 16'd2, nBeats: 10, expOut: 8, expErr: 1,
                  sol: 16'h0011, eol: 16'h0088, sof: 16'h0001, eof: 16'h0080};
      vecs[3] = '{w: 16'd1, h: 16'd1, nBeats: 1,  expOut: 1, expErr: 0,
                  sol: 16'h0001, eol: 16'h0001, sof: 16'h0001, eof: 16'h0001};
      vecs[4] = '{w: 16'd2, h: 16'd2, nBeats: 4,  expOut: 4, expErr: 0,
                  sol: 16'h0005, eol: 16'h000A, sof: 16'h0001, eof: 16'h0008};
      vecs[5] = '{w: 16'd3, h: 16'd1, nBeats: 2,  expOut: 2, expErr: 1,
                  sol: 16'h0001, eol: 16'h0002, sof: 16'h0001, eof: 16'h0002};

      $display("[TB] frame table");
      for (int i = 0; i < 6; i++) begin
         runFrame(vecs[i], i);
      end
      $display("[TB] backpressure");
      runBackpressure();
      $display("[TB] mid-frame geometry change");
      runMidFrameCtrl();
      $display("[TB] mid-frame reset");
      runMidFrameReset();
      $display("[TB] randomized run");
      runRandom(3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
